// File: rtl/piso_pkg.sv
// Shared state type and beat-count helper for the PISO serializer.
// The optional gapless-streaming hold stage is enabled by PISO_PRELOAD_EN.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  function automatic int unsigned beats(input int unsigned ds, input int unsigned lw);
    return ds / lw;
  endfunction

endpackage

// File: rtl/piso_hold_buffer.sv
// One-word hold register (word + bit-order flag + full flag) for gapless streaming.
// Only exists in builds with PISO_PRELOAD_EN defined.
`ifdef PISO_PRELOAD_EN
module piso_hold_buffer
  import piso_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 msb_in,
  output logic                 full,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 msb_out
);

  logic                 full_q, full_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 msb_q,  msb_d;

  // Push and pop are mutually exclusive: push needs empty, pop needs full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    msb_d  = msb_q;
    if (push) begin
      full_d = 1'b1;
      data_d = data_in;
      msb_d  = msb_in;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      msb_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      msb_q  <= msb_d;
    end
  end

  assign full     = full_q;
  assign data_out = data_q;
  assign msb_out  = msb_q;

endmodule
`endif

// File: rtl/piso_serializer.sv
// Parallel-to-serial shifter: one DATA_SIZE word in over valid/ready, LANE_WIDTH bits out per
// enabled beat, LSB- or MSB-first. Define PISO_PRELOAD_EN for a hold stage enabling gapless words.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 64,
  parameter int unsigned LANE_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_SIZE-1:0]  DATA_IN,
  input  logic                  LOAD_VALID,
  output logic                  LOAD_READY,
  input  logic                  MSB_FIRST,
  input  logic                  SHIFT_EN,
  output logic [LANE_WIDTH-1:0] DATA_OUT,
  output logic                  DATA_VALID,
  output logic                  LAST,
  output logic                  BUSY
);

  localparam int unsigned BEATS = beats(DATA_SIZE, LANE_WIDTH);
  localparam int unsigned CNT_W = $clog2(BEATS + 1);

  if ((DATA_SIZE % LANE_WIDTH) != 0) begin : g_bad_lane
    $error("piso_serializer: DATA_SIZE must be a multiple of LANE_WIDTH");
  end

  piso_state_t           state_q, state_d;
  logic [DATA_SIZE-1:0]  shreg_q, shreg_d;
  logic                  msb_q, msb_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LANE_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  last_q, last_d;
  logic                  load_ready_q, load_ready_d;
  logic                  busy_q;
  logic                  load_fire;
  logic                  final_beat;

  assign load_fire  = LOAD_VALID && load_ready_q;
  assign final_beat = (cnt_q == CNT_W'(1));

`ifdef PISO_PRELOAD_EN
  logic                 hold_push, hold_pop, hold_full, hold_msb;
  logic [DATA_SIZE-1:0] hold_data;

  piso_hold_buffer #(
    .DATA_SIZE (DATA_SIZE)
  ) u_hold (
    .clk      (CLK),
    .rst      (RST),
    .push     (hold_push),
    .pop      (hold_pop),
    .data_in  (DATA_IN),
    .msb_in   (MSB_FIRST),
    .full     (hold_full),
    .data_out (hold_data),
    .msb_out  (hold_msb)
  );
`endif

  // Next-state, shifter and beat counter.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    msb_d        = msb_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    last_d       = 1'b0;
`ifdef PISO_PRELOAD_EN
    hold_push    = 1'b0;
    hold_pop     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (load_fire) begin
          state_d = SHIFT;
          shreg_d = DATA_IN;
          msb_d   = MSB_FIRST;
          cnt_d   = CNT_W'(BEATS);
        end
      end
      SHIFT: begin
        if (SHIFT_EN) begin
          data_out_d   = msb_q ? shreg_q[DATA_SIZE-1 -: LANE_WIDTH] : shreg_q[LANE_WIDTH-1:0];
          shreg_d      = msb_q ? (shreg_q << LANE_WIDTH) : (shreg_q >> LANE_WIDTH);
          cnt_d        = cnt_q - CNT_W'(1);
          data_valid_d = 1'b1;
          last_d       = final_beat;
          if (final_beat) begin
            state_d = IDLE;
          end
        end
`ifdef PISO_PRELOAD_EN
        // Final beat reloads from the hold stage, or from the port if a word arrives right then.
        if (SHIFT_EN && final_beat && hold_full) begin
          hold_pop = 1'b1;
          state_d  = SHIFT;
          shreg_d  = hold_data;
          msb_d    = hold_msb;
          cnt_d    = CNT_W'(BEATS);
        end else if (load_fire) begin
          if (SHIFT_EN && final_beat) begin
            state_d = SHIFT;
            shreg_d = DATA_IN;
            msb_d   = MSB_FIRST;
            cnt_d   = CNT_W'(BEATS);
          end else begin
            hold_push = 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef PISO_PRELOAD_EN
    load_ready_d = !(hold_push || (hold_full && !hold_pop));
`else
    load_ready_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      msb_q        <= 1'b0;
      cnt_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      last_q       <= 1'b0;
      load_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      msb_q        <= msb_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      last_q       <= last_d;
      load_ready_q <= load_ready_d;
      busy_q       <= (state_d == SHIFT);
    end
  end

  assign LOAD_READY = load_ready_q;
  assign DATA_OUT   = data_out_q;
  assign DATA_VALID = data_valid_q;
  assign LAST       = last_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an 8x1 LSB/MSB instance and an 8x2 instance.
// Builds with or without PISO_PRELOAD_EN; streaming expectations follow the build.
module tb_piso_serializer;

`ifdef PISO_PRELOAD_EN
  localparam bit PRELOAD = 1'b1;
`else
  localparam bit PRELOAD = 1'b0;
`endif

  logic       clk;
  logic       rst;

  logic [7:0] d1_din;
  logic       d1_lv, d1_ready, d1_msb, d1_se, d1_dout, d1_valid, d1_last, d1_busy;

  logic [7:0] d2_din;
  logic       d2_lv, d2_ready, d2_msb, d2_se, d2_valid, d2_last, d2_busy;
  logic [1:0] d2_dout;

  int n_cmp  = 0;
  int n_fail = 0;

  piso_serializer #(.DATA_SIZE(8), .LANE_WIDTH(1)) u_dut1 (
    .CLK(clk), .RST(rst), .DATA_IN(d1_din), .LOAD_VALID(d1_lv), .LOAD_READY(d1_ready),
    .MSB_FIRST(d1_msb), .SHIFT_EN(d1_se), .DATA_OUT(d1_dout), .DATA_VALID(d1_valid),
    .LAST(d1_last), .BUSY(d1_busy)
  );

  piso_serializer #(.DATA_SIZE(8), .LANE_WIDTH(2)) u_dut2 (
    .CLK(clk), .RST(rst), .DATA_IN(d2_din), .LOAD_VALID(d2_lv), .LOAD_READY(d2_ready),
    .MSB_FIRST(d2_msb), .SHIFT_EN(d2_se), .DATA_OUT(d2_dout), .DATA_VALID(d2_valid),
    .LAST(d2_last), .BUSY(d2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       lv;
    logic [7:0] din;
    logic       msb;
    logic       se;
    logic       e_valid;
    logic       e_out;
    logic       e_last;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];
  logic exp_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] exp_b4 [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic lv, input logic [7:0] din, input logic msb, input logic se,
                     input logic ev, input logic eo, input logic el, input logic eb);
    vec_t v;
    v.lv = lv; v.din = din; v.msb = msb; v.se = se;
    v.e_valid = ev; v.e_out = eo; v.e_last = el; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  // Feed nwords LSB-first words on dut1 with SHIFT_EN held high, collecting the serial stream.
  task automatic stream_words(input logic [7:0] w0, input logic [7:0] w1, input int nwords,
                              output logic [15:0] stream, output int nb,
                              output logic [15:0] last_mask, output int span,
                              output int rb, output int stray);
    int   idx     = 0;
    int   first_c = -1;
    int   last_c  = -1;
    logic fire;
    stream = '0; last_mask = '0; nb = 0; rb = 0; stray = 0;
    d1_msb = 1'b0;
    d1_se  = 1'b1;
    for (int c = 0; c < 48 && nb < 8 * nwords; c++) begin
      d1_lv  = (idx < nwords);
      d1_din = (idx == 0) ? w0 : w1;
      fire   = d1_lv && d1_ready;
      @(posedge clk); #1;
      if (fire) idx++;
      if (d1_ready && d1_busy) rb++;
      if (d1_last && !d1_valid) stray++;
      if (d1_valid) begin
        stream[nb] = d1_dout;
        if (d1_last) last_mask[nb] = 1'b1;
        if (first_c < 0) first_c = c;
        last_c = c;
        nb++;
      end
    end
    d1_lv = 1'b0;
    d1_se = 1'b0;
    span  = last_c - first_c;
  endtask

  initial begin
    logic [15:0] stream, last_mask;
    int          nb, span, rb, stray;

    rst = 1'b1;
    d1_lv = 1'b0; d1_din = '0; d1_msb = 1'b0; d1_se = 1'b0;
    d2_lv = 1'b0; d2_din = '0; d2_msb = 1'b0; d2_se = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst dout",  32'(d1_dout),  32'd0);
    check("rst valid", 32'(d1_valid), 32'd0);
    check("rst last",  32'(d1_last),  32'd0);
    check("rst busy",  32'(d1_busy),  32'd0);
    check("rst ready", 32'(d1_ready), 32'd0);
    check("rst dout2", 32'(d2_dout),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready after rst",  32'(d1_ready), 32'd1);
    check("ready2 after rst", 32'(d2_ready), 32'd1);

    // 0xA5 LSB-first continuous, then idle SHIFT_EN, then 0xA5 with SHIFT_EN toggling
    add(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++)
      add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, exp_a5[k], (k == 7), (k != 7));
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, exp_a5[7], 1'b0, 1'b0);
    add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, exp_a5[7], 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++)
      add(1'b0, 8'h00, 1'b0, logic'(k % 2), logic'(k % 2), exp_a5[(k + 1) / 2 - 1],
          (k == 15), (k < 15));

    foreach (vecs[i]) begin
      d1_lv = vecs[i].lv; d1_din = vecs[i].din; d1_msb = vecs[i].msb; d1_se = vecs[i].se;
      @(posedge clk); #1;
      check($sformatf("vec%0d valid", i), 32'(d1_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d dout", i),  32'(d1_dout),  32'(vecs[i].e_out));
      check($sformatf("vec%0d last", i),  32'(d1_last),  32'(vecs[i].e_last));
      check($sformatf("vec%0d busy", i),  32'(d1_busy),  32'(vecs[i].e_busy));
      check($sformatf("vec%0d ready", i), 32'(d1_ready), 32'(PRELOAD ? 1'b1 : !vecs[i].e_busy));
    end
    d1_lv = 1'b0; d1_se = 1'b0;

    // 8x2 MSB-first 0xB4
    d2_lv = 1'b1; d2_din = 8'hB4; d2_msb = 1'b1; d2_se = 1'b1;
    @(posedge clk); #1;
    d2_lv = 1'b0;
    check("lw2 first edge valid", 32'(d2_valid), 32'd0);
    nb = 0;
    for (int c = 0; c < 12 && nb < 4; c++) begin
      @(posedge clk); #1;
      if (d2_valid) begin
        check($sformatf("lw2 slice%0d", nb), 32'(d2_dout), 32'(exp_b4[nb]));
        check($sformatf("lw2 last%0d", nb),  32'(d2_last), 32'(nb == 3));
        nb++;
      end
    end
    check("lw2 beat count", 32'(nb), 32'd4);
    d2_se = 1'b0;
    @(posedge clk); #1;
    check("lw2 busy after word", 32'(d2_busy), 32'd0);

    // Two words offered back to back: 0x0F then 0xF0
    stream_words(8'h0F, 8'hF0, 2, stream, nb, last_mask, span, rb, stray);
    check("two beats",     32'(nb),        32'd16);
    check("two stream",    32'(stream),    32'hF00F);
    check("two last mask", 32'(last_mask), 32'h8080);
    check("two span",      32'(span),      PRELOAD ? 32'd15 : 32'd16);
    check("two ready busy", 32'(rb),       PRELOAD ? 32'd9 : 32'd0);
    check("two stray last", 32'(stray),    32'd0);
    @(posedge clk); #1;

    // Reset after 3 beats of 0xFF
    d1_lv = 1'b1; d1_din = 8'hFF; d1_msb = 1'b0; d1_se = 1'b1;
    @(posedge clk); #1;
    d1_lv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("ff beat%0d valid", k), 32'(d1_valid), 32'd1);
      check($sformatf("ff beat%0d dout", k),  32'(d1_dout),  32'd1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst dout",  32'(d1_dout),  32'd0);
    check("midrst valid", 32'(d1_valid), 32'd0);
    check("midrst last",  32'(d1_last),  32'd0);
    check("midrst busy",  32'(d1_busy),  32'd0);
    check("midrst ready", 32'(d1_ready), 32'd0);
    rst = 1'b0;
    d1_se = 1'b0;
    @(posedge clk); #1;
    check("postrst ready", 32'(d1_ready), 32'd1);
    check("postrst last",  32'(d1_last),  32'd0);

    stream_words(8'hA5, 8'h00, 1, stream, nb, last_mask, span, rb, stray);
    check("reload beats",  32'(nb),        32'd8);
    check("reload stream", 32'(stream),    32'h00A5);
    check("reload last",   32'(last_mask), 32'h0080);
    check("reload span",   32'(span),      32'd7);
    check("reload stray",  32'(stray),     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
